chunked_subtractor: RTL
=======================

// Module: chunked_subtractor
// PURPOSE
//   Parametrised multi-cycle subtractor: diff = a - b - bin over WIDTH bits, with borrow out.
//   Processes CHUNK bits per clock, rippling the borrow through a register.
//   Replaces the single-bit combinational full subtractor on datapaths where wide operands
//   must meet timing. Uses a valid/ready handshake on both the input and the output side.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be >= 1
//   CHUNK    4  bits processed per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0
//   (derived) NCHUNK = WIDTH/CHUNK, the number of RUN cycles
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a, b, bin are valid
//   in_ready   out  1      block can accept an operation (high only in IDLE)
//   a          in   WIDTH  minuend, unsigned or two's complement
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result is valid (high only in DONE)
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      borrow out: 1 iff a < b + bin, taken as unsigned
//   zero       out  1      1 iff diff == 0
//   ovf        out  1      signed overflow = (borrow into MSB) XOR (borrow out of MSB)
// BEHAVIOUR
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid & in_ready at a clock edge:
//       latch a, b; borrow_reg <= bin; chunk index <= 0; go to RUN.
//   - RUN: each cycle, compute chunk i (bits i*CHUNK +: CHUNK) as
//       {bo, d} = a_i - b_i - borrow_reg.
//     Write d into diff[i]; borrow_reg <= bo; i <= i+1.
//     After chunk NCHUNK-1, go to DONE; register bout, zero and ovf on that same edge.
//   - DONE: out_valid=1; diff, bout, zero and ovf are held stable.
//     On out_valid & out_ready, go to IDLE. in_ready stays 0 in this cycle, so there is
//     no same-cycle re-accept.
//   Latency: out_valid rises exactly NCHUNK edges after the accepting edge.
//     Throughput: at most one operation per NCHUNK+2 cycles.
//   in_valid is ignored in RUN and DONE. Operand inputs may change freely after the accept.
//   diff is only meaningful while out_valid=1. Intermediate chunk values may be visible
//     during RUN.
//   All arithmetic is modulo 2^WIDTH. bout equals the final borrow_reg.
//   ovf is computed from the borrow entering the MSB and the borrow leaving the MSB.
//   Reset (rst_n=0, asynchronous, any state, including mid-RUN): state=IDLE; diff=0;
//     bout=0; zero=0; ovf=0; out_valid=0; borrow_reg=0; index=0.
//     in_ready=1 once in IDLE. An aborted operation produces no output.
//   out_ready held high in DONE: exactly one transfer, then IDLE on the next edge.
//   WIDTH=CHUNK: NCHUNK=1, so there is a single RUN cycle and latency is 1 edge.
// TESTING
//   1. Instance WIDTH=1, CHUNK=1: drive all 8 {a,b,bin} combos -> {bout,diff} matches the
//      full-subtractor truth table (e.g. 0,1,1 -> diff=0, bout=1; 1,0,1 -> diff=0, bout=0).
//   2. WIDTH=16, CHUNK=4: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, zero=0, ovf=0;
//      out_valid exactly 4 edges after the accept.
//   3. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0 (borrow ripples through all
//      4 chunks). a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0.
//   4. a=0x0005, b=0x0004, bin=1 -> diff=0x0000, zero=1, bout=0.
//   5. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b
//      -> outputs stable, in_ready=0. Raise out_ready -> one transfer, then IDLE.
//   6. Pull rst_n low after 2 RUN edges -> out_valid=0 and diff=0 immediately. After release,
//      a=0x00FF, b=0x000F -> diff=0x00F0. Also cover back-to-back ops with in_valid held high.

Source files
------------

// File: rtl/chunked_subtractor_if.sv
// rtl/chunked_subtractor_if.sv - operand/result handshake bundle for chunked_subtractor
// Purpose: groups the input (operands) and output (result) valid/ready channels.
// Ports:
//   in_valid, in_ready  - operand channel handshake
//   a, b, bin           - minuend, subtrahend, borrow in
//   out_valid, out_ready- result channel handshake
//   diff, bout, zero, ovf - difference, borrow out, zero flag, signed overflow
// Modports: master drives operands and out_ready; slave is the subtractor.
interface chunked_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, zero, ovf
   );
endinterface

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle a - b - bin, CHUNK bits per clock
// Purpose: computes diff = a - b - bin (mod 2^WIDTH) one CHUNK-wide slice per
//   cycle, rippling the borrow through a register; reports borrow out, zero
//   and signed overflow.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - chunked_subtractor_if slave: operand and result handshakes
module chunked_subtractor #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   chunked_subtractor_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic [IW-1:0]    idx;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             bout_q;
   logic             zero_q;
   logic             ovf_q;

   int               sel;
   logic [CHUNK-1:0] a_i;
   logic [CHUNK-1:0] b_i;
   logic [CHUNK-1:0] d_i;
   logic             bo_i;
   logic             bmsb_i;
   logic [WIDTH-1:0] diff_next;

   always_comb begin
      sel = int'(idx) * CHUNK;
      a_i = a_q[sel +: CHUNK];
      b_i = b_q[sel +: CHUNK];
      // One extra bit catches the borrow: a negative slice result wraps with its top bit set.
      {bo_i, d_i} = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, borrow_q};
      // Bit-level identity d = a ^ b ^ borrow_in recovers the borrow entering the slice MSB,
      // which on the last slice is the borrow into the word MSB.
      bmsb_i = d_i[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
      diff_next = diff_q;
      diff_next[sel +: CHUNK] = d_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         idx         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
               if (bus.in_valid) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  borrow_q   <= bus.bin;
                  idx        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               diff_q   <= diff_next;
               borrow_q <= bo_i;
               if (idx == IW'(NCHUNK - 1)) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  bout_q      <= bo_i;
                  zero_q      <= (diff_next == '0);
                  ovf_q       <= bmsb_i ^ bo_i;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               // in_ready rises only after this edge, so a result transfer never overlaps an accept.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
endmodule
